// File: rtl/mem_port_arbiter_if.sv
// Bus bundle shared by the two requesters, the arbiter and the RAM macro.
// The arbiter takes the slave view: it receives requests and drives the RAM.
// The requester/RAM side (CPU, loader, RAM model) takes the master view.
interface mem_port_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 32
);

   // Port A: CPU fetch/load/store
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;

   // Port B: program loader / debug host
   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_hold;
   logic          b_gnt;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;

   // CPU freeze request
   logic          cpu_halt;

   // Single-port synchronous RAM
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic          ram_wren;
   logic [DW-1:0] ram_q;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata, b_hold,
      output b_gnt, b_rvalid, b_rdata,
      output cpu_halt,
      output ram_addr, ram_data, ram_wren,
      input  ram_q
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata, b_hold,
      input  b_gnt, b_rvalid, b_rdata,
      input  cpu_halt,
      input  ram_addr, ram_data, ram_wren,
      output ram_q
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of one single-port synchronous RAM.
// Port A is the CPU, port B the program loader / debug host.  One access is
// granted per cycle; reads return one cycle later, tagged with the owner
// recorded at grant time.  Port B can take exclusive ownership through
// b_hold, which drains any CPU read in flight and then freezes the CPU.
module mem_port_arbiter #(
   parameter int AW = 16,
   parameter int DW = 32
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      DRAIN  = 2'd1,
      LOCKED = 2'd2
   } hold_state_t;

   typedef enum logic {
      OWNER_A = 1'b0,
      OWNER_B = 1'b1
   } owner_t;

   hold_state_t   hold_state;
   owner_t        last_owner;

   logic          a_allowed;
   logic          a_pick;
   logic          b_pick;
   logic          a_gnt;
   logic          b_gnt;
   logic          a_read_issue;

   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;
   logic          a_rvalid_q;
   logic          b_rvalid_q;
   logic          cpu_halt_q;

   // Arbitration decision: port A only competes while the bus is FREE; on
   // a tie the port that did not win last time gets the slot.
   always_comb begin
      a_allowed = (hold_state == FREE);
      a_pick    = 1'b0;
      b_pick    = 1'b0;
      if (a_allowed && bus.a_req && bus.b_req) begin
         if (last_owner == OWNER_A) begin
            b_pick = 1'b1;
         end else begin
            a_pick = 1'b1;
         end
      end else if (a_allowed && bus.a_req) begin
         a_pick = 1'b1;
      end else if (bus.b_req) begin
         b_pick = 1'b1;
      end
   end

   // Grants are squashed while reset is asserted so nothing reaches the RAM.
   assign a_gnt        = a_pick & rst_n;
   assign b_gnt        = b_pick & rst_n;
   assign a_read_issue = a_gnt & ~bus.a_we;

   assign bus.a_gnt    = a_gnt;
   assign bus.b_gnt    = b_gnt;

   // RAM drive: the granted port passes straight through in the grant cycle;
   // otherwise the address/data of the last grant are replayed from a
   // register so the RAM pins never glitch back to zero between accesses.
   always_comb begin
      bus.ram_addr = addr_q;
      bus.ram_data = data_q;
      bus.ram_wren = 1'b0;
      if (a_gnt) begin
         bus.ram_addr = bus.a_addr;
         bus.ram_data = bus.a_wdata;
         bus.ram_wren = bus.a_we;
      end else if (b_gnt) begin
         bus.ram_addr = bus.b_addr;
         bus.ram_data = bus.b_wdata;
         bus.ram_wren = bus.b_we;
      end
   end

   // Owner history, replay registers and read-return tags.  The tag is set
   // at grant, so the RAM output one cycle later is steered to the right port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= OWNER_B;
         addr_q     <= '0;
         data_q     <= '0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
      end else begin
         if (a_gnt) begin
            last_owner <= OWNER_A;
            addr_q     <= bus.a_addr;
            data_q     <= bus.a_wdata;
         end else if (b_gnt) begin
            last_owner <= OWNER_B;
            addr_q     <= bus.b_addr;
            data_q     <= bus.b_wdata;
         end
         a_rvalid_q <= a_read_issue;
         b_rvalid_q <= b_gnt & ~bus.b_we;
      end
   end

   // Hold state machine with registered cpu_halt.  The only CPU read that can
   // still be in flight on entry to DRAIN is one granted in the last FREE
   // cycle; its data is returned during the DRAIN cycle, and since A cannot
   // be granted in DRAIN the pipe is empty after that edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_state <= FREE;
         cpu_halt_q <= 1'b0;
      end else begin
         case (hold_state)
            FREE: begin
               if (bus.b_hold) begin
                  hold_state <= DRAIN;
                  cpu_halt_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (!bus.b_hold) begin
                  hold_state <= FREE;
                  cpu_halt_q <= 1'b0;
               end else if (!a_read_issue) begin
                  hold_state <= LOCKED;
                  cpu_halt_q <= 1'b1;
               end
            end
            LOCKED: begin
               if (!bus.b_hold) begin
                  hold_state <= FREE;
                  cpu_halt_q <= 1'b0;
               end
            end
            default: begin
               hold_state <= FREE;
               cpu_halt_q <= 1'b0;
            end
         endcase
      end
   end

   // Read return: RAM output is shown only to the tagged owner, zero otherwise.
   assign bus.a_rvalid = a_rvalid_q;
   assign bus.b_rvalid = b_rvalid_q;
   assign bus.a_rdata  = a_rvalid_q ? bus.ram_q : '0;
   assign bus.b_rdata  = b_rvalid_q ? bus.ram_q : '0;
   assign bus.cpu_halt = cpu_halt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.  A small synchronous RAM model
// sits behind the arbiter; a table of per-cycle vectors covers plain
// accesses and round-robin ties, and hand-written sequences cover the hold
// handshake, an aborted drain and a reset in the middle of a read.
module tb_mem_port_arbiter;

   typedef struct {
      logic        a_req;
      logic        a_we;
      logic [15:0] a_addr;
      logic [31:0] a_wdata;
      logic        b_req;
      logic        b_we;
      logic [15:0] b_addr;
      logic [31:0] b_wdata;
      logic        b_hold;
      logic        e_a_gnt;
      logic        e_b_gnt;
      logic        e_wren;
      logic [15:0] e_addr;
      logic [31:0] e_data;
      logic        e_a_rvalid;
      logic [31:0] e_a_rdata;
      logic        e_b_rvalid;
      logic [31:0] e_b_rdata;
      logic        e_halt;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] mem [0:255];
   int          nChecks;
   int          nFails;
   vec_t        vecs [13];
   vec_t        v;

   mem_port_arbiter_if #(.AW(16), .DW(32)) bus ();

   mem_port_arbiter #(.AW(16), .DW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous single-port RAM model, read data one cycle after address
   always @(posedge clk) begin
      if (bus.ram_wren) begin
         mem[bus.ram_addr[7:0]] <= bus.ram_data;
      end
      bus.ram_q <= mem[bus.ram_addr[7:0]];
   end

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input vec_t x);
      bus.a_req   = x.a_req;
      bus.a_we    = x.a_we;
      bus.a_addr  = x.a_addr;
      bus.a_wdata = x.a_wdata;
      bus.b_req   = x.b_req;
      bus.b_we    = x.b_we;
      bus.b_addr  = x.b_addr;
      bus.b_wdata = x.b_wdata;
      bus.b_hold  = x.b_hold;
   endtask

   task automatic applyStimulus(input vec_t x);
      @(negedge clk);
      driveInputs(x);
      #2;
   endtask

   task automatic checkOutput(input vec_t x, input string tag);
      checkVal({tag, ".a_gnt"},    32'(bus.a_gnt),    32'(x.e_a_gnt));
      checkVal({tag, ".b_gnt"},    32'(bus.b_gnt),    32'(x.e_b_gnt));
      checkVal({tag, ".ram_wren"}, 32'(bus.ram_wren), 32'(x.e_wren));
      checkVal({tag, ".ram_addr"}, 32'(bus.ram_addr), 32'(x.e_addr));
      checkVal({tag, ".ram_data"}, bus.ram_data,      x.e_data);
      checkVal({tag, ".a_rvalid"}, 32'(bus.a_rvalid), 32'(x.e_a_rvalid));
      checkVal({tag, ".a_rdata"},  bus.a_rdata,       x.e_a_rdata);
      checkVal({tag, ".b_rvalid"}, 32'(bus.b_rvalid), 32'(x.e_b_rvalid));
      checkVal({tag, ".b_rdata"},  bus.b_rdata,       x.e_b_rdata);
      checkVal({tag, ".cpu_halt"}, 32'(bus.cpu_halt), 32'(x.e_halt));
   endtask

   initial begin
      nChecks = 0;
      nFails  = 0;
      rst_n   = 1'b0;
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0;
      end
      mem[8'h10] = 32'hDEADBEEF;
      v = '{1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0,
            1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
      driveInputs(v);

      // Field order: a_req a_we a_addr a_wdata | b_req b_we b_addr b_wdata b_hold |
      //              a_gnt b_gnt wren addr data | a_rvalid a_rdata b_rvalid b_rdata halt
      vecs[0]  = '{1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b0,1'b0,1'b0,16'h0000,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[1]  = '{1'b1,1'b0,16'h0010,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b1,1'b0,1'b0,16'h0010,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[2]  = '{1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b0,1'b0,1'b0,16'h0010,32'h0,        1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b0};
      vecs[3]  = '{1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b1,16'h0020,32'h5,        1'b0,
                   1'b0,1'b1,1'b1,16'h0020,32'h5,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[4]  = '{1'b1,1'b0,16'h0020,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b1,1'b0,1'b0,16'h0020,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[5]  = '{1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b0,1'b0,1'b0,16'h0020,32'h0,        1'b1,32'h5,        1'b0,32'h0,        1'b0};
      vecs[6]  = '{1'b0,1'b0,16'h0000,32'h0,        1'b1,1'b0,16'h0010,32'h0,        1'b0,
                   1'b0,1'b1,1'b0,16'h0010,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[7]  = '{1'b1,1'b1,16'h0040,32'hA1,       1'b1,1'b0,16'h0020,32'h0,        1'b0,
                   1'b1,1'b0,1'b1,16'h0040,32'hA1,       1'b0,32'h0,        1'b1,32'hDEADBEEF, 1'b0};
      vecs[8]  = '{1'b1,1'b0,16'h0010,32'h0,        1'b1,1'b0,16'h0020,32'h0,        1'b0,
                   1'b0,1'b1,1'b0,16'h0020,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[9]  = '{1'b1,1'b0,16'h0010,32'h0,        1'b1,1'b1,16'h0050,32'hB2,       1'b0,
                   1'b1,1'b0,1'b0,16'h0010,32'h0,        1'b0,32'h0,        1'b1,32'h5,        1'b0};
      vecs[10] = '{1'b1,1'b1,16'h0060,32'hA3,       1'b1,1'b1,16'h0050,32'hB2,       1'b0,
                   1'b0,1'b1,1'b1,16'h0050,32'hB2,       1'b1,32'hDEADBEEF, 1'b0,32'h0,        1'b0};
      vecs[11] = '{1'b1,1'b0,16'h0040,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b1,1'b0,1'b0,16'h0040,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0};
      vecs[12] = '{1'b0,1'b0,16'h0000,32'h0,        1'b0,1'b0,16'h0000,32'h0,        1'b0,
                   1'b0,1'b0,1'b0,16'h0040,32'h0,        1'b1,32'hA1,       1'b0,32'h0,        1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Table: reset state, single accesses, write-then-read, tie alternation
      for (int i = 0; i < 13; i++) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], $sformatf("vec%0d", i));
      end

      // Hold: A read granted while b_hold rises, read still returned in DRAIN
      v = '{1'b1,1'b0,16'h0010,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b1,
            1'b1,1'b0,1'b0,16'h0010,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "hold_grant");
      v = '{1'b1,1'b0,16'h0020,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b1,
            1'b0,1'b0,1'b0,16'h0010,32'h0, 1'b1,32'hDEADBEEF, 1'b0,32'h0, 1'b1};
      applyStimulus(v);
      checkOutput(v, "hold_drain");

      // LOCKED: B writes 8 words while A keeps trying to store to 0x70
      for (int k = 0; k < 8; k++) begin
         v = '{1'b1,1'b1,16'h0070,32'hFFFFFFFF, 1'b1,1'b1,16'h0100 + 16'(k),32'h1000 + 32'(k), 1'b1,
               1'b0,1'b1,1'b1,16'h0100 + 16'(k),32'h1000 + 32'(k), 1'b0,32'h0, 1'b0,32'h0, 1'b1};
         applyStimulus(v);
         checkOutput(v, $sformatf("locked_wr%0d", k));
      end

      // b_hold falls: still LOCKED this cycle, FREE and A granted the next
      v = '{1'b1,1'b0,16'h0103,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0107,32'h1007, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
      applyStimulus(v);
      checkOutput(v, "release_locked");
      v = '{1'b1,1'b0,16'h0103,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b1,1'b0,1'b0,16'h0103,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "release_free");
      v = '{1'b1,1'b0,16'h0070,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b1,1'b0,1'b0,16'h0070,32'h0, 1'b1,32'h1003, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "readback_loaded");
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0070,32'h0, 1'b1,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "blocked_store");

      // Drain aborted: b_hold drops while in DRAIN, straight back to FREE
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b1,
            1'b0,1'b0,1'b0,16'h0070,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "abort_rise");
      v = '{1'b1,1'b0,16'h0040,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0070,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
      applyStimulus(v);
      checkOutput(v, "abort_drain");
      v = '{1'b1,1'b0,16'h0040,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b1,1'b0,1'b0,16'h0040,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "abort_free");
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0040,32'h0, 1'b1,32'hA1, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "abort_read");

      // Reset pulsed while a B read is being granted: its rvalid is lost
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b1,1'b0,16'h0010,32'h0, 1'b0,
            1'b0,1'b1,1'b0,16'h0010,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "pre_reset_grant");
      #1;
      rst_n = 1'b0;
      v = '{1'b1,1'b1,16'h0030,32'h77, 1'b1,1'b1,16'h0031,32'h88, 1'b0,
            1'b0,1'b0,1'b0,16'h0000,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      driveInputs(v);
      #1;
      checkOutput(v, "in_reset");
      @(negedge clk);
      checkOutput(v, "in_reset_after_edge");
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0000,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      driveInputs(v);
      rst_n = 1'b1;

      // After reset last_owner is B, so A wins the first tie
      v = '{1'b1,1'b0,16'h0010,32'h0, 1'b1,1'b0,16'h0020,32'h0, 1'b0,
            1'b1,1'b0,1'b0,16'h0010,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "post_reset_tie");
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b1,1'b0,16'h0020,32'h0, 1'b0,
            1'b0,1'b1,1'b0,16'h0020,32'h0, 1'b1,32'hDEADBEEF, 1'b0,32'h0, 1'b0};
      applyStimulus(v);
      checkOutput(v, "post_reset_b");
      v = '{1'b0,1'b0,16'h0000,32'h0, 1'b0,1'b0,16'h0000,32'h0, 1'b0,
            1'b0,1'b0,1'b0,16'h0020,32'h0, 1'b0,32'h0, 1'b1,32'h5, 1'b0};
      applyStimulus(v);
      checkOutput(v, "post_reset_b_read");

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
